uart_rx_frontend: RTL and testbench

Serial-to-byte receiver feeding the command-assembly stage of the calculator path.
- Oversamples the asynchronous `rx` line, detects 8N1 frames, LSB first, and delivers each valid byte on `rx_data`.
- Signals each delivery with a one-cycle `rx_data_ready` pulse. The downstream stage counts these pulses to collect operation, operand A and operand B.
- Flags malformed frames without delivering data.

---
 rtl/uart_rx_frontend_if.sv | 26 ++
 rtl/uart_rx_frontend.sv | 157 +++++++++++++++
 tb/tb_uart_rx_frontend.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frontend_if.sv
// Bundle of the serial input and the byte-level outputs of the UART receive
// front end. The receiver is the slave (it consumes rx and produces data);
// whoever drives the line and watches the outputs is the master.
interface uart_rx_frontend_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic       frame_error;
  logic       busy;

  modport slave (
    input  rx,
    output rx_data,
    output rx_data_ready,
    output frame_error,
    output busy
  );

  modport master (
    output rx,
    input  rx_data,
    input  rx_data_ready,
    input  frame_error,
    input  busy
  );
endinterface

// File: rtl/uart_rx_frontend.sv
// UART 8N1 receiver front end. Synchronises the asynchronous rx line, finds the
// start bit, samples each bit in its middle, and delivers the byte with a
// one-cycle ready pulse. A low stop bit produces a single frame_error pulse and
// the receiver then waits for the line to return high before re-arming.
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic                clk,
  input  logic                reset,
  uart_rx_frontend_if.slave   bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic             sync1_r, sync2_r;
  logic             rx_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       bit_r, bit_s;
  logic [7:0]       shift_r, shift_s;
  logic [7:0]       rx_data_r, rx_data_s;
  logic             ready_r, ready_s;
  logic             ferr_r, ferr_s;
  logic             busy_r;

  assign rx_s = sync2_r;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= bus.rx;
      sync2_r <= sync1_r;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      bit_r     <= 3'd0;
      shift_r   <= 8'h00;
      rx_data_r <= 8'h00;
      ready_r   <= 1'b0;
      ferr_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_r     <= bit_s;
      shift_r   <= shift_s;
      rx_data_r <= rx_data_s;
      ready_r   <= ready_s;
      ferr_r    <= ferr_s;
      busy_r    <= (state_s != IDLE);
    end
  end

  // Next-state logic: mid-bit sampling driven by the baud counter, which is
  // cleared at every sample point so it never wraps on its own.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_s     = bit_r;
    shift_s   = shift_r;
    rx_data_s = rx_data_r;
    ready_s   = 1'b0;
    ferr_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_s = START;
          cnt_s   = '0;
        end else begin
          cnt_s   = '0;
        end
      end
      START: begin
        if (cnt_r == HALF_M1) begin
          cnt_s = '0;
          bit_s = 3'd0;
          if (!rx_s) begin
            state_s = DATA;
          end else begin
            // Start bit gone by mid-bit: treat as a glitch.
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_r == FULL_M1) begin
          cnt_s          = '0;
          shift_s[bit_r] = rx_s;
          if (bit_r == LAST_BIT) begin
            state_s = STOP;
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_r == FULL_M1) begin
          cnt_s = '0;
          if (rx_s) begin
            // Return to IDLE at once so a back-to-back start bit is caught.
            state_s   = IDLE;
            rx_data_s = shift_r;
            ready_s   = 1'b1;
          end else begin
            state_s = BREAK_WAIT;
            ferr_s  = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      BREAK_WAIT: begin
        // A held-low line yields one error only; re-arm once it goes high.
        if (rx_s) begin
          state_s = IDLE;
        end else begin
          state_s = BREAK_WAIT;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        bit_s   = 3'd0;
      end
    endcase
  end

  assign bus.rx_data       = rx_data_r;
  assign bus.rx_data_ready = ready_r;
  assign bus.frame_error   = ferr_r;
  assign bus.busy          = busy_r;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend with CLKS_PER_BIT = 8.
module tb_uart_rx_frontend;

  localparam int CPB = 8;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  uart_rx_frontend_if bus ();

  uart_rx_frontend #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter and output monitor (sampled on the falling edge).
  int         cyc;
  int         ready_cnt, ferr_cnt, both_cnt, long_cnt, busy_cyc, last_ready_cyc;
  logic       prev_ready, prev_ferr;
  logic [7:0] got_q[$];

  initial begin
    cyc = 0; ready_cnt = 0; ferr_cnt = 0; both_cnt = 0; long_cnt = 0;
    busy_cyc = 0; last_ready_cyc = 0; prev_ready = 1'b0; prev_ferr = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_data_ready === 1'b1) begin
      ready_cnt      = ready_cnt + 1;
      last_ready_cyc = cyc;
      got_q.push_back(bus.rx_data);
    end
    if (bus.frame_error === 1'b1) ferr_cnt = ferr_cnt + 1;
    if (bus.rx_data_ready === 1'b1 && bus.frame_error === 1'b1) both_cnt = both_cnt + 1;
    if ((prev_ready && bus.rx_data_ready === 1'b1) || (prev_ferr && bus.frame_error === 1'b1))
      long_cnt = long_cnt + 1;
    if (bus.busy === 1'b1) busy_cyc = busy_cyc + 1;
    prev_ready = (bus.rx_data_ready === 1'b1);
    prev_ferr  = (bus.frame_error === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    bus.rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      tick(CPB);
    end
    bus.rx = stop;
    tick(CPB);
  endtask

  int r0, f0, b0, t_start;
  logic [7:0] op_m, a_m, b_m;

  initial begin
    tests = 0;
    fails = 0;
    reset  = 1'b1;
    bus.rx = 1'b1;
    tick(3);
    check("reset_rx_data", 32'(bus.rx_data), 32'h00);
    check("reset_ready",   32'(bus.rx_data_ready), 32'h0);
    check("reset_ferr",    32'(bus.frame_error), 32'h0);
    check("reset_busy",    32'(bus.busy), 32'h0);
    reset = 1'b0;
    tick(4);

    // 1: single frame 0xA5, latency from the raw falling edge.
    r0 = ready_cnt; f0 = ferr_cnt;
    t_start = cyc;
    send_frame(8'hA5, 1'b1);
    tick(4);
    check("t1_ready_count", 32'(ready_cnt - r0), 32'd1);
    check("t1_rx_data",     32'(bus.rx_data), 32'hA5);
    check("t1_logged",      32'(got_q[r0]), 32'hA5);
    check("t1_latency_raw", 32'(last_ready_cyc - t_start), 32'd79);
    check("t1_ferr_count",  32'(ferr_cnt - f0), 32'd0);
    check("t1_busy_idle",   32'(bus.busy), 32'h0);

    // 2: back-to-back frames with no idle gap; downstream counting model.
    r0 = ready_cnt; f0 = ferr_cnt;
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    tick(4);
    check("t2_ready_count", 32'(ready_cnt - r0), 32'd3);
    op_m = got_q[r0]; a_m = got_q[r0 + 1]; b_m = got_q[r0 + 2];
    check("t2_operation",   32'(op_m), 32'h01);
    check("t2_operand_a",   32'(a_m),  32'h02);
    check("t2_operand_b",   32'(b_m),  32'h03);
    check("t2_ferr_count",  32'(ferr_cnt - f0), 32'd0);

    // 3: 3-cycle glitch on an idle line.
    r0 = ready_cnt; f0 = ferr_cnt; b0 = busy_cyc;
    bus.rx = 1'b0;
    tick(3);
    bus.rx = 1'b1;
    tick(16);
    check("t3_ready_count", 32'(ready_cnt - r0), 32'd0);
    check("t3_ferr_count",  32'(ferr_cnt - f0), 32'd0);
    check("t3_busy_seen",   32'(busy_cyc - b0 > 0), 32'd1);
    check("t3_busy_bound",  32'(busy_cyc - b0 <= 6), 32'd1);
    check("t3_busy_end",    32'(bus.busy), 32'h0);
    check("t3_rx_data",     32'(bus.rx_data), 32'h03);

    // 4: good frame then a frame with a low stop bit.
    r0 = ready_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b1);
    send_frame(8'h77, 1'b0);
    bus.rx = 1'b1;
    tick(6);
    check("t4_ready_count", 32'(ready_cnt - r0), 32'd1);
    check("t4_logged",      32'(got_q[r0]), 32'h3C);
    check("t4_ferr_count",  32'(ferr_cnt - f0), 32'd1);
    check("t4_rx_data",     32'(bus.rx_data), 32'h3C);

    // 5: line held low for 40 bit times, released, then 0x5A.
    r0 = ready_cnt; f0 = ferr_cnt;
    bus.rx = 1'b0;
    tick(40 * CPB);
    check("t5_busy_low",    32'(bus.busy), 32'h1);
    bus.rx = 1'b1;
    tick(4);
    check("t5_ferr_once",   32'(ferr_cnt - f0), 32'd1);
    check("t5_idle_again",  32'(bus.busy), 32'h0);
    send_frame(8'h5A, 1'b1);
    tick(4);
    check("t5_ready_count", 32'(ready_cnt - r0), 32'd1);
    check("t5_rx_data",     32'(bus.rx_data), 32'h5A);
    check("t5_ferr_total",  32'(ferr_cnt - f0), 32'd1);

    // 6: reset in the middle of data bit 4 of 0xFF, then 0x81.
    r0 = ready_cnt; f0 = ferr_cnt;
    bus.rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      bus.rx = 1'b1;
      tick(CPB);
    end
    tick(CPB / 2);
    check("t6_busy_mid",    32'(bus.busy), 32'h1);
    reset = 1'b1;
    #1;
    check("t6_async_data",  32'(bus.rx_data), 32'h00);
    check("t6_async_busy",  32'(bus.busy), 32'h0);
    check("t6_async_ready", 32'(bus.rx_data_ready), 32'h0);
    check("t6_async_ferr",  32'(bus.frame_error), 32'h0);
    tick(3);
    reset = 1'b0;
    tick(4);
    check("t6_no_pulse",    32'(ready_cnt - r0), 32'd0);
    send_frame(8'h81, 1'b1);
    tick(4);
    check("t6_ready_count", 32'(ready_cnt - r0), 32'd1);
    check("t6_rx_data",     32'(bus.rx_data), 32'h81);
    check("t6_ferr_count",  32'(ferr_cnt - f0), 32'd0);

    // Global pulse properties.
    check("never_both",     32'(both_cnt), 32'd0);
    check("single_cycle",   32'(long_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
